alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Registered execute stage that consumes the 3-bit alucontrol/addsub pair from the ALU-control decoder.
//  Applies it to two operands and returns result plus flags.
//  Uses a valid/ready handshake on both sides. A 2-entry buffer (output reg + skid reg) gives full throughput
//  and a registered in_ready. Sits between operand fetch/decode and writeback.
// PARAMETERS
//  WIDTH     32   operand/result width in bits (>=2)
// PORTS
//  clk         in   1      clock, all state on rising edge
//  reset       in   1      asynchronous, active-high reset
//  in_valid    in   1      upstream presents an operation
//  in_ready    out  1      stage can accept; = !skid_full (registered state, no comb path from out_ready)
//  a           in   WIDTH  operand A
//  b           in   WIDTH  operand B
//  alucontrol  in   3      op select (encoding below)
//  addsub      in   1      0=add, 1=subtract; only meaningful when alucontrol=100
//  out_valid   out  1      result register holds a valid op
//  out_ready   in   1      downstream accepts result
//  result      out  WIDTH  operation result
//  zero        out  1      result == 0
//  carry       out  1      add/sub carry-out (sub: 1 = no borrow); 0 for other ops
//  overflow    out  1      signed overflow for add/sub; 0 for other ops
//  illegal     out  1      alucontrol was an undefined code
// BEHAVIOUR
//  - Encoding: 000 AND, 001 OR, 010 NOR, 011 XOR, 100 ADD/SUB (addsub). Codes 101/110/111 are illegal.
//  - Illegal op: result=0, zero=1, carry=0, overflow=0, illegal=1.
//  - Add/sub: sum = a + (b ^ {WIDTH{addsub}}) + addsub, computed at WIDTH+1 bits; carry = bit WIDTH.
//    overflow = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]), with bb the inverted-or-not b.
//  - Flags are computed combinationally at accept time and stored with the result; never recomputed at output.
//  - Reset (async, immediate): out_valid=0, skid empty (in_ready=1), result=0, zero=0, carry=0, overflow=0, illegal=0.
//    Skid contents cleared. Reset mid-stream discards all in-flight ops; nothing is emitted afterwards.
//  - Accept event acc = in_valid && in_ready. Output slot free: fre = !out_valid || out_ready.
//  - Per cycle, with priority:
//      fre && skid_full : out <= skid; skid_full <= acc ? 1 : 0; skid <= new op if acc
//      fre && !skid_full: out <= new op if acc, else out_valid <= 0
//      !fre && acc      : skid <= new op; skid_full <= 1   (out held stable)
//      !fre && !acc     : hold everything
//  - Latency: accept at edge N -> out_valid/result at edge N (visible after N), when the output is not stalled.
//  - Throughput: 1 op/cycle while out_ready=1.
//  - While out_valid && !out_ready, result and all flags hold stable. Ordering is strictly FIFO; no drop, no duplicate.
//  - Simultaneous out_ready and in_valid with skid full: in_ready is 0 that cycle, so no accept.
//    Skid moves to out; in_ready returns to 1 next cycle.
//  - in_valid while in_ready=0: no state change; upstream must hold its op.
// STRUCTURE
//  - alu_pkg: localparams ALU_AND=3'b000, ALU_OR=3'b001, ALU_NOR=3'b010, ALU_XOR=3'b011, ALU_ADDSUB=3'b100.
//    Also typedef alu_res_t {result, zero, carry, overflow, illegal} sized by WIDTH.
//  - Sub-module alu_core: purely combinational (a, b, alucontrol, addsub) -> alu_res_t.
//    The stage holds only the handshake/skid logic and two alu_res_t registers.
// TESTING
//  1. Reset while out_valid=1 and skid full.
//     -> same cycle: out_valid=0, in_ready=1, result=0; no later emission of old ops.
//  2. ADD a=32'h7FFFFFFF, b=1, addsub=0.
//     -> next cycle result=32'h80000000, overflow=1, carry=0, zero=0.
//  3. SUB a=5, b=5 -> result=0, zero=1, carry=1, overflow=0.
//     SUB a=3, b=5 -> result=32'hFFFFFFFE, carry=0.
//  4. a=32'hF0F0F0F0, b=32'hFF00FF00: AND -> F000F000, OR -> FFF0FFF0, XOR -> 0FF00FF0, NOR -> 000F000F.
//     Flags carry/overflow=0.
//  5. Stream 6 back-to-back ops; out_ready=0 for 3 cycles after first output.
//     -> in_ready drops after 2nd accept, all 6 results emerge in order, then 1/cycle resumes.
//  6. alucontrol=3'b101 -> result=0, illegal=1, zero=1; next op 3'b000 clears illegal.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: op encodings and the stored result/flag bundle.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] ALU_AND    = 3'b000;
    localparam logic [2:0] ALU_OR     = 3'b001;
    localparam logic [2:0] ALU_NOR    = 3'b010;
    localparam logic [2:0] ALU_XOR    = 3'b011;
    localparam logic [2:0] ALU_ADDSUB = 3'b100;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic                 zero;
        logic                 carry;
        logic                 overflow;
        logic                 illegal;
    } alu_res_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: applies the alucontrol/addsub pair to two operands and forms all flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int  WIDTH = ALU_WIDTH,
    parameter type res_t = alu_res_t
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alucontrol,
    input  logic             addsub,
    output res_t             res
);

    logic [WIDTH-1:0] bb_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] result_s;

    // Shared adder: subtraction is a + ~b + 1, so carry=1 means no borrow.
    always_comb begin
        bb_s  = b ^ {WIDTH{addsub}};
        sum_s = {1'b0, a} + {1'b0, bb_s} + {{WIDTH{1'b0}}, addsub};
    end

    // Op select and flag formation; undefined codes yield a zero result with illegal set.
    always_comb begin
        res      = '0;
        result_s = {WIDTH{1'b0}};
        case (alucontrol)
            ALU_AND: result_s = a & b;
            ALU_OR:  result_s = a | b;
            ALU_NOR: result_s = ~(a | b);
            ALU_XOR: result_s = a ^ b;
            ALU_ADDSUB: begin
                result_s     = sum_s[WIDTH-1:0];
                res.carry    = sum_s[WIDTH];
                res.overflow = (a[WIDTH-1] == bb_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            default: begin
                result_s    = {WIDTH{1'b0}};
                res.illegal = 1'b1;
            end
        endcase
        res.result = result_s;
        res.zero   = (result_s == {WIDTH{1'b0}});
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with valid/ready on both sides; an output register plus a skid
// register give full throughput while keeping in_ready a pure register output.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alucontrol,
    input  logic             addsub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             carry;
        logic             overflow;
        logic             illegal;
    } stage_res_t;

    stage_res_t new_res_s;
    stage_res_t out_r;
    stage_res_t skid_r;
    logic       out_valid_r;
    logic       skid_full_r;
    logic       acc_s;
    logic       fre_s;

    alu_core #(
        .WIDTH (WIDTH),
        .res_t (stage_res_t)
    ) u_core (
        .a          (a),
        .b          (b),
        .alucontrol (alucontrol),
        .addsub     (addsub),
        .res        (new_res_s)
    );

    // Accept and output-slot-free conditions; in_ready depends only on registered skid state.
    always_comb begin
        acc_s = in_valid && !skid_full_r;
        fre_s = !out_valid_r || out_ready;
    end

    // Output register and skid register; the skid always drains ahead of new ops to keep FIFO order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_r       <= '0;
            skid_r      <= '0;
            out_valid_r <= 1'b0;
            skid_full_r <= 1'b0;
        end else if (fre_s && skid_full_r) begin
            out_r       <= skid_r;
            out_valid_r <= 1'b1;
            if (acc_s) begin
                skid_r      <= new_res_s;
                skid_full_r <= 1'b1;
            end else begin
                skid_full_r <= 1'b0;
            end
        end else if (fre_s) begin
            if (acc_s) begin
                out_r       <= new_res_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (acc_s) begin
            skid_r      <= new_res_s;
            skid_full_r <= 1'b1;
        end else begin
            out_r       <= out_r;
            skid_r      <= skid_r;
            out_valid_r <= out_valid_r;
            skid_full_r <= skid_full_r;
        end
    end

    assign in_ready  = !skid_full_r;
    assign out_valid = out_valid_r;
    assign result    = out_r.result;
    assign zero      = out_r.zero;
    assign carry     = out_r.carry;
    assign overflow  = out_r.overflow;
    assign illegal   = out_r.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: arithmetic reference model plus an occupancy-queue scoreboard.
module tb_alu_exec_stage;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   alucontrol;
    logic         addsub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         overflow;
    logic         illegal;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         c;
        logic         v;
        logic         il;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    alu_exec_stage #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .alucontrol (alucontrol),
        .addsub     (addsub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .carry      (carry),
        .overflow   (overflow),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Reference: plain signed/unsigned 64-bit arithmetic, no adder-bit tricks.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [2:0] ctl, input logic s);
        exp_t                  e;
        longint                sa;
        longint                sb;
        longint                sr;
        longint unsigned       ua;
        longint unsigned       ub;
        e  = '0;
        sa = $signed(x);
        sb = $signed(y);
        ua = x;
        ub = y;
        case (ctl)
            3'd0: e.r = x & y;
            3'd1: e.r = x | y;
            3'd2: e.r = ~(x | y);
            3'd3: e.r = x ^ y;
            3'd4: begin
                if (!s) begin
                    sr  = sa + sb;
                    e.r = x + y;
                    e.c = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
                end else begin
                    sr  = sa - sb;
                    e.r = x - y;
                    e.c = (ua >= ub);
                end
                e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            default: e.il = 1'b1;
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model occupancy: items accepted but not yet consumed downstream, in order.
    always @(posedge clk or posedge reset) begin
        bit can_acc;
        if (reset) begin
            q.delete();
        end else begin
            can_acc = (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && can_acc) q.push_back(model(a, b, alucontrol, addsub));
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("out_valid", out_valid, q.size() > 0);
            check("in_ready", in_ready, q.size() < 2);
            if (q.size() > 0 && out_valid)
                check("payload", {result, zero, carry, overflow, illegal}, q[0]);
        end
    end

    task automatic drive_new();
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
        alucontrol = ($urandom_range(0, 1) == 1) ? 3'd4 : 3'($urandom_range(0, 7));
        addsub = 1'($urandom_range(0, 1));
    endtask

    task automatic do_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2:0] ctl, input logic s, input exp_t exp);
        @(posedge clk);
        #1;
        a = x; b = y; alucontrol = ctl; addsub = s; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check(name, {out_valid, result, zero, carry, overflow, illegal}, {1'b1, exp});
    endtask

    task automatic stream(input int n, input bit rnd);
        int sent = 0;
        int cyc  = 0;
        bit rdy;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive_new();
        in_valid = 1'b1;
        while (sent < n && cyc < 5000) begin
            @(negedge clk);
            if (!rnd && cyc == 2) check("stall_in_ready_low", in_ready, 1'b0);
            rdy = in_ready;
            @(posedge clk);
            #1;
            cyc++;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 1 && cyc <= 3);
            if (in_valid && rdy) begin
                sent++;
                if (sent < n && (!rnd || $urandom_range(0, 4) != 0)) begin
                    drive_new();
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end else if (!in_valid && sent < n && (!rnd || $urandom_range(0, 1) == 1)) begin
                drive_new();
                in_valid = 1'b1;
            end
        end
        check("stream_sent", sent, n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #1;
        check("stream_drained", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 32'd0; b = 32'd0; alucontrol = 3'd0; addsub = 1'b0;
        #2;
        check("reset_state", {out_valid, in_ready, result, zero, carry, overflow, illegal},
              {1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1 reset = 1'b0;

        check("model_add_ovf", model(32'h7FFF_FFFF, 32'd1, 3'd4, 1'b0), {32'h8000_0000, 4'b0010});
        check("model_sub_neg", model(32'd3, 32'd5, 3'd4, 1'b1), {32'hFFFF_FFFE, 4'b0000});
        check("model_nor", model(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd2, 1'b0), {32'h000F_000F, 4'b0000});

        do_op("add_ovf", 32'h7FFF_FFFF, 32'd1, 3'd4, 1'b0, {32'h8000_0000, 4'b0010});
        do_op("add_wrap", 32'hFFFF_FFFF, 32'd1, 3'd4, 1'b0, {32'h0000_0000, 4'b1100});
        do_op("sub_eq", 32'd5, 32'd5, 3'd4, 1'b1, {32'h0000_0000, 4'b1100});
        do_op("sub_neg", 32'd3, 32'd5, 3'd4, 1'b1, {32'hFFFF_FFFE, 4'b0000});
        do_op("sub_ovf", 32'h8000_0000, 32'd1, 3'd4, 1'b1, {32'h7FFF_FFFF, 4'b0110});
        do_op("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd0, 1'b0, {32'hF000_F000, 4'b0000});
        do_op("or", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd1, 1'b1, {32'hFFF0_FFF0, 4'b0000});
        do_op("xor", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd3, 1'b0, {32'h0FF0_0FF0, 4'b0000});
        do_op("nor", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd2, 1'b0, {32'h000F_000F, 4'b0000});
        do_op("illegal_101", 32'h1234_5678, 32'h9ABC_DEF0, 3'd5, 1'b0, {32'h0000_0000, 4'b1001});
        do_op("after_illegal", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd0, 1'b0, {32'hF000_F000, 4'b0000});
        do_op("illegal_111", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7, 1'b1, {32'h0000_0000, 4'b1001});

        stream(6, 1'b0);
        stream(400, 1'b1);

        // Fill output and skid, then reset asynchronously between edges.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive_new();
        in_valid = 1'b1;
        @(posedge clk);
        #1 drive_new();
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_full", {out_valid, in_ready}, 2'b10);
        #2 reset = 1'b1;
        #1;
        check("async_reset", {out_valid, in_ready, result, zero, carry, overflow, illegal},
              {1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_emit_after_reset", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
